// File: rtl/eth_pkg.sv
// eth_pkg: shared types and helpers for the Ethernet TX FCS datapath.
//   - eth_tx_state_e : frame sequencer states (IDLE, DATA, PAD, FCS)
//   - CRC32_INIT     : CRC-32 register start value
//   - CRC32_RESIDUE  : register value left after running the CRC over data+FCS
//   - bit_reverse8   : byte bit-order reversal (LSB-first line order)
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } eth_tx_state_e;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-parallel IEEE 802.3 CRC-32 register.
// Ports:
//   Clk      - system clock
//   Reset_n  - synchronous active-low reset, loads CRC32_INIT
//   Init_i   - reload CRC32_INIT (wins over Enable_i)
//   Enable_i - fold Data_i into the register
//   Data_i   - byte as it appears on the line; reversed here so the
//              MSB-first shift processes the byte LSB first
//   Crc_o    - current register value (non-reflected form)
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Init_i,
    input  logic        Enable_i,
    input  logic [7:0]  Data_i,
    output logic [31:0] Crc_o
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[31] ^ d[i]) ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (Init_i) begin
            crc_d = CRC32_INIT;
        end else if (Enable_i) begin
            crc_d = crc_next(crc_q, bit_reverse8(Data_i));
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign Crc_o = crc_q;

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// eth_tx_fcs_ctrl: TX frame sequencer. Passes frame bytes to the line side
// through a one-entry output register, runs CRC-32 over them and appends the
// 4-byte FCS after the last byte.
// Optional feature: define ETH_TX_PAD_EN to zero-pad short frames to
// MIN_FRAME bytes (pad covered by the CRC). Without it frames go out unpadded.
// Ports:
//   Clk, Reset_n                      - clock, synchronous active-low reset
//   In_data/In_valid/In_last/In_ready - input byte stream
//   Out_data/Out_valid/Out_last/Out_ready - line-side byte stream
//   Frame_done  - one-cycle pulse after the last FCS byte is accepted
//   Byte_count  - length of the completed frame incl. pad, excl. FCS
module eth_tx_fcs_ctrl
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [7:0]       In_data,
    input  logic             In_valid,
    input  logic             In_last,
    output logic             In_ready,
    output logic [7:0]       Out_data,
    output logic             Out_valid,
    output logic             Out_last,
    input  logic             Out_ready,
    output logic             Frame_done,
    output logic [CNT_W-1:0] Byte_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef ETH_TX_PAD_EN
    localparam logic [CNT_W-1:0] MinFrameC = CNT_W'(MIN_FRAME);
`else
    // MIN_FRAME has no role when padding is not built in.
    localparam int unsigned unused_min_frame = MIN_FRAME;
`endif

    eth_tx_state_e    state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fcs_idx_q, fcs_idx_d;

    logic             crc_init, crc_en;
    logic [7:0]       crc_in;
    logic [31:0]      crc;
    logic [7:0]       crc_sel;
    logic [7:0]       fcs_byte;
    logic [CNT_W-1:0] cnt_inc;
    logic             out_free, out_xfer, in_xfer;

    eth_crc32_d8 u_crc (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Init_i   (crc_init),
        .Enable_i (crc_en),
        .Data_i   (crc_in),
        .Crc_o    (crc)
    );

    assign out_xfer = valid_q && Out_ready;
    // Output register can take a new byte if empty or emptying this cycle.
    assign out_free = !valid_q || Out_ready;
    assign In_ready = ((state_q == IDLE) || (state_q == DATA)) && out_free;
    assign in_xfer  = In_valid && In_ready;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // FCS bytes go out top CRC byte first, each complemented and bit-reversed.
    always_comb begin
        case (fcs_idx_q)
            2'd0:    crc_sel = crc[31:24];
            2'd1:    crc_sel = crc[23:16];
            2'd2:    crc_sel = crc[15:8];
            default: crc_sel = crc[7:0];
        endcase
        fcs_byte = ~bit_reverse8(crc_sel);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        bcnt_d    = bcnt_q;
        cnt_d     = cnt_q;
        fcs_idx_d = fcs_idx_q;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        crc_in    = 8'h00;

        if (out_xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (in_xfer) begin
                    data_d  = In_data;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_en  = 1'b1;
                    crc_in  = In_data;
                    cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_inc;
                    if (In_last) begin
                        fcs_idx_d = 2'd0;
                        state_d   = FCS;
`ifdef ETH_TX_PAD_EN
                        if (cnt_d < MinFrameC) begin
                            state_d = PAD;
                        end
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                if (out_free) begin
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    crc_en  = 1'b1;
                    crc_in  = 8'h00;
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= MinFrameC) begin
                        state_d = FCS;
                    end
                end
            end
`endif
            FCS: begin
                // last_q marks that byte 3 is already loaded; wait for its transfer.
                if (out_xfer && last_q) begin
                    done_d   = 1'b1;
                    bcnt_d   = cnt_q;
                    crc_init = 1'b1;
                    state_d  = IDLE;
                end else if (out_free && !last_q) begin
                    data_d    = fcs_byte;
                    valid_d   = 1'b1;
                    last_d    = (fcs_idx_q == 2'd3);
                    fcs_idx_d = fcs_idx_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            bcnt_q    <= '0;
            cnt_q     <= '0;
            fcs_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            bcnt_q    <= bcnt_d;
            cnt_q     <= cnt_d;
            fcs_idx_q <= fcs_idx_d;
        end
    end

    assign Out_data   = data_q;
    assign Out_valid  = valid_q;
    assign Out_last   = last_q;
    assign Frame_done = done_q;
    assign Byte_count = bcnt_q;

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Testbench for eth_tx_fcs_ctrl. Works with or without ETH_TX_PAD_EN.
module tb_eth_tx_fcs_ctrl;
    import eth_pkg::*;

    localparam int MIN_F = 60;
    localparam int CW    = 16;

    typedef logic [7:0] bq_t[$];

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [7:0]    In_data = 8'h00;
    logic          In_valid = 1'b0;
    logic          In_last = 1'b0;
    logic          In_ready;
    logic [7:0]    Out_data;
    logic          Out_valid;
    logic          Out_last;
    logic          Out_ready = 1'b1;
    logic          Frame_done;
    logic [CW-1:0] Byte_count;

    eth_tx_fcs_ctrl #(.MIN_FRAME(MIN_F), .CNT_W(CW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .In_data    (In_data),
        .In_valid   (In_valid),
        .In_last    (In_last),
        .In_ready   (In_ready),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_last   (Out_last),
        .Out_ready  (Out_ready),
        .Frame_done (Frame_done),
        .Byte_count (Byte_count)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = -10;
    int done_cnt = 0;
    int done_err = 0;
    int stall_err = 0;
    int first_acc = 0;
    int last_at_acc = 0;
    bit stall = 1'b0;

    bq_t got_q;
    logic got_last[$];
    int   bc_q[$];

    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle after the driver has settled Out_ready.
    always @(negedge Clk) begin
        #2;
        if (Reset_n) begin
            if (hold_pend && (!Out_valid || Out_data !== hold_data || Out_last !== hold_last))
                stall_err++;
            hold_pend = Out_valid && !Out_ready;
            hold_data = Out_data;
            hold_last = Out_last;
            if (Out_valid && Out_ready) begin
                got_q.push_back(Out_data);
                got_last.push_back(Out_last);
                if (Out_last) last_cyc = cyc;
            end
            if (Frame_done) begin
                done_cnt++;
                bc_q.push_back(int'(Byte_count));
                if (cyc != last_cyc + 1) done_err++;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reflected (LSB-first) CRC-32, register value without final inversion.
    function automatic logic [31:0] ref_crc(input bq_t d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Expected line-side bytes for a frame: data, optional zero pad, FCS LSB first.
    function automatic bq_t model(input bq_t d);
        bq_t e;
        logic [31:0] c;
        e = d;
`ifdef ETH_TX_PAD_EN
        while (e.size() < MIN_F) e.push_back(8'h00);
`endif
        c = ~ref_crc(e);
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        return e;
    endfunction

    task automatic drive_ready();
        Out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step_idle();
        @(negedge Clk);
        drive_ready();
        In_valid = 1'b0;
        In_last  = 1'($urandom_range(0, 1));
        In_data  = 8'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset_n  = 1'b0;
        In_valid = 1'b0;
        In_last  = 1'b0;
        Out_ready = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
    endtask

    task automatic run_frame(input bq_t d, input bit with_last);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < d.size() && guard < 5000) begin
            @(negedge Clk);
            drive_ready();
            In_valid = 1'b1;
            In_data  = d[idx];
            In_last  = with_last && (idx == d.size() - 1);
            #1;
            if (In_ready) begin
                if (idx == 0) begin
                    first_acc   = cyc;
                    last_at_acc = last_cyc;
                end
                idx++;
            end
            guard++;
        end
        chk("input_accepted", idx, d.size());
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_cnt < target && g < 2000) begin
            step_idle();
            g++;
        end
        chk("frame_done_seen", done_cnt, target);
        repeat (3) step_idle();
        chk("frame_done_single", done_cnt, target);
    endtask

    task automatic check_frame(input string tag, input bq_t d);
        bq_t e;
        bq_t g;
        int n;
        e = model(d);
        n = got_q.size();
        foreach (got_last[i]) begin
            if (got_last[i] && n == got_q.size()) n = i + 1;
        end
        chk({tag, "_len"}, n, e.size());
        for (int i = 0; i < n; i++) begin
            g.push_back(got_q[0]);
            if (i < e.size()) begin
                chk({tag, "_byte"}, got_q[0], e[i]);
                chk({tag, "_last"}, got_last[0], (i == e.size() - 1));
            end
            void'(got_q.pop_front());
            void'(got_last.pop_front());
        end
        chk({tag, "_residue"}, rev32(ref_crc(g)), CRC32_RESIDUE);
        chk({tag, "_bc_avail"}, bc_q.size() > 0, 1);
        if (bc_q.size() > 0) chk({tag, "_byte_count"}, bc_q.pop_front(), e.size() - 4);
    endtask

    initial begin
        bq_t ascii, f64, fa, fb, one;
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        one   = '{8'h00};

        // Reset state
        apply_reset();
        chk("rst_out_valid", Out_valid, 0);
        chk("rst_out_last", Out_last, 0);
        chk("rst_out_data", Out_data, 0);
        chk("rst_frame_done", Frame_done, 0);
        chk("rst_byte_count", Byte_count, 0);
        chk("rst_in_ready", In_ready, 1);

        // "123456789", no backpressure
        stall = 1'b0;
        run_frame(ascii, 1'b1);
        wait_done(1);
`ifndef ETH_TX_PAD_EN
        chk("ascii_fcs0", got_q[9], 8'h26);
        chk("ascii_fcs1", got_q[10], 8'h39);
        chk("ascii_fcs2", got_q[11], 8'hF4);
        chk("ascii_fcs3", got_q[12], 8'hCB);
        chk("ascii_byte_count_pin", Byte_count, 9);
`else
        chk("ascii_byte_count_pin", Byte_count, MIN_F);
`endif
        check_frame("ascii", ascii);

        // 64 random bytes with random backpressure
        f64 = {};
        for (int i = 0; i < 64; i++) f64.push_back(8'($urandom));
        stall = 1'b1;
        run_frame(f64, 1'b1);
        wait_done(2);
        check_frame("rand64", f64);
        chk("stall_hold", stall_err, 0);

        // Back-to-back frames, In_valid held high
        stall = 1'b0;
        fa = {};
        fb = {};
        for (int i = 0; i < 20; i++) fa.push_back(8'($urandom));
        for (int i = 0; i < 70; i++) fb.push_back(8'($urandom));
        run_frame(fa, 1'b1);
        run_frame(fb, 1'b1);
        chk("b2b_first_accept", first_acc, last_at_acc + 1);
        wait_done(4);
        check_frame("b2b_a", fa);
        check_frame("b2b_b", fb);

        // Reset after byte 5 of a frame
        run_frame(ascii[0:4], 1'b0);
        apply_reset();
        chk("mid_rst_out_valid", Out_valid, 0);
        chk("mid_rst_out_last", Out_last, 0);
        chk("mid_rst_out_data", Out_data, 0);
        chk("mid_rst_frame_done", Frame_done, 0);
        chk("mid_rst_byte_count", Byte_count, 0);
        chk("mid_rst_in_ready", In_ready, 1);
        got_q.delete();
        got_last.delete();
        run_frame(ascii, 1'b1);
        wait_done(5);
`ifndef ETH_TX_PAD_EN
        chk("post_rst_fcs0", got_q[9], 8'h26);
        chk("post_rst_fcs1", got_q[10], 8'h39);
        chk("post_rst_fcs2", got_q[11], 8'hF4);
        chk("post_rst_fcs3", got_q[12], 8'hCB);
`endif
        check_frame("post_rst", ascii);

        // Single-byte frame 00, with backpressure
        stall = 1'b1;
        run_frame(one, 1'b1);
        wait_done(6);
`ifndef ETH_TX_PAD_EN
        chk("one_data", got_q[0], 8'h00);
        chk("one_fcs0", got_q[1], 8'h8D);
        chk("one_fcs1", got_q[2], 8'hEF);
        chk("one_fcs2", got_q[3], 8'h02);
        chk("one_fcs3", got_q[4], 8'hD2);
        chk("one_byte_count_pin", Byte_count, 1);
`endif
        check_frame("one", one);

        chk("stall_hold_final", stall_err, 0);
        chk("frame_done_timing", done_err, 0);
        chk("no_extra_output", got_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
